// File: rtl/arrow_scheduler_pkg.sv
// Shared dance-game definitions: lane encoding, screen geometry and scheduler states.
package ddr_pkg;

  localparam int NUM_LANES = 4;
  localparam int Y_W       = 10;

  typedef enum logic [1:0] {
    LANE_LEFT  = 2'd0,
    LANE_DOWN  = 2'd1,
    LANE_UP    = 2'd2,
    LANE_RIGHT = 2'd3
  } lane_e;

  localparam int SPAWN_Y_DEF  = 0;
  localparam int HIT_LO_DEF   = 400;
  localparam int HIT_HI_DEF   = 440;
  localparam int RETIRE_Y_DEF = 480;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_JUDGE  = 3'd2,
    S_SPAWN0 = 3'd3,
    S_SPAWN1 = 3'd4,
    S_SPAWN2 = 3'd5,
    S_SPAWN3 = 3'd6
  } sched_state_e;

endpackage

// File: rtl/arrow_scheduler_slot_alloc.sv
// Lowest-index priority encoder: returns the first set bit of avail and whether one exists.
module slot_alloc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  avail,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (avail[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Arrow pool scheduler: per-frame move, hit judging and pattern-driven spawning.
//   state   | meaning
//   IDLE    | wait for frame tick with enable high
//   MOVE    | advance all active arrows, retire misses, step frame counter
//   JUDGE   | clear one in-window arrow per pressed lane
//   SPAWN0-3| allocate an arrow for lane k if the pattern step asks for it
module arrow_scheduler
  import ddr_pkg::*;
#(
  parameter int NUM_SLOTS       = 8,
  parameter int FRAMES_PER_STEP = 8,
  parameter int SPEED           = 8,
  parameter int SPAWN_Y         = SPAWN_Y_DEF,
  parameter int HIT_LO          = HIT_LO_DEF,
  parameter int HIT_HI          = HIT_HI_DEF,
  parameter int RETIRE_Y        = RETIRE_Y_DEF,
  parameter int SONG_LEN        = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 hc,
  input  logic [9:0]                 vc,
  input  logic                       enable,
  input  logic [NUM_LANES-1:0]       btn,
  output logic [7:0]                 pattern_addr,
  input  logic [NUM_LANES-1:0]       pattern_data,
  output logic [NUM_SLOTS-1:0]       slot_active,
  output logic [2*NUM_SLOTS-1:0]     slot_lane,
  output logic [Y_W*NUM_SLOTS-1:0]   slot_y,
  output logic [NUM_LANES-1:0]       hit_lanes,
  output logic [3:0]                 miss_count,
  output logic                       overflow,
  output logic                       song_done
);

  localparam int IW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int YN_W = Y_W + 1;

  sched_state_e          state;
  logic [Y_W-1:0]        y_q       [NUM_SLOTS];
  lane_e                 lane_q    [NUM_SLOTS];
  logic [FC_W-1:0]       frame_cnt;
  logic                  step_flag;
  logic                  addr_done;
  logic [NUM_LANES-1:0]  btn_pend;
  logic [NUM_LANES-1:0]  press;
  logic                  tick;
  logic [YN_W-1:0]       y_next    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  retire;
  logic [3:0]            miss_sum;
  logic [NUM_SLOTS-1:0]  cand_mask [NUM_LANES];
  logic [IW-1:0]         cand_idx  [NUM_LANES];
  logic [NUM_LANES-1:0]  cand_found;
  logic [IW-1:0]         free_idx;
  logic                  free_found;
  logic [2:0]            spawn_off;
  logic [1:0]            spawn_k;

  assign tick      = (hc == '0) && (vc == '0);
  assign press     = btn_pend | btn;
  assign spawn_off = state - S_SPAWN0;
  assign spawn_k   = spawn_off[1:0];

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign slot_y[g*Y_W +: Y_W] = y_q[g];
    assign slot_lane[g*2 +: 2]  = lane_q[g];
  end

  // One extra bit on y_next makes the retire compare immune to 10-bit wrap.
  always_comb begin
    miss_sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      y_next[i] = {1'b0, y_q[i]} + YN_W'(SPEED);
      retire[i] = slot_active[i] && (y_next[i] >= YN_W'(RETIRE_Y));
      miss_sum  = miss_sum + 4'(retire[i]);
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cand_mask[l][i] = slot_active[i] && (lane_q[i] == lane_e'(l)) &&
                          (y_q[i] >= Y_W'(HIT_LO)) && (y_q[i] <= Y_W'(HIT_HI));
      end
    end
  end

  slot_alloc #(.N(NUM_SLOTS), .IW(IW)) u_free (
    .avail (~slot_active),
    .idx   (free_idx),
    .found (free_found)
  );

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_judge
    slot_alloc #(.N(NUM_SLOTS), .IW(IW)) u_cand (
      .avail (cand_mask[l]),
      .idx   (cand_idx[l]),
      .found (cand_found[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      slot_active  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        y_q[i]    <= '0;
        lane_q[i] <= LANE_LEFT;
      end
      pattern_addr <= '0;
      frame_cnt    <= '0;
      step_flag    <= 1'b0;
      addr_done    <= 1'b0;
      btn_pend     <= '0;
      hit_lanes    <= '0;
      miss_count   <= '0;
      overflow     <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      hit_lanes  <= '0;
      miss_count <= '0;
      overflow   <= 1'b0;
      btn_pend   <= (state == S_IDLE && !enable) ? '0 : press;
      if (addr_done && slot_active == '0) song_done <= 1'b1;

      case (state)
        S_IDLE: if (tick && enable) state <= S_MOVE;
        S_MOVE: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (retire[i])           slot_active[i] <= 1'b0;
            else if (slot_active[i]) y_q[i]         <= y_next[i][Y_W-1:0];
          end
          miss_count <= miss_sum;
          if (frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) begin
            frame_cnt <= '0;
            step_flag <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
          state <= S_JUDGE;
        end
        S_JUDGE: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (press[l] && cand_found[l]) begin
              slot_active[cand_idx[l]] <= 1'b0;
              hit_lanes[l]             <= 1'b1;
            end
          end
          btn_pend  <= '0;
          step_flag <= 1'b0;
          state     <= (step_flag && !addr_done) ? S_SPAWN0 : S_IDLE;
        end
        default: begin
          if (pattern_data[spawn_k]) begin
            if (free_found) begin
              slot_active[free_idx] <= 1'b1;
              y_q[free_idx]         <= Y_W'(SPAWN_Y);
              lane_q[free_idx]      <= lane_e'(spawn_k);
            end else begin
              overflow <= 1'b1;
            end
          end
          if (state == S_SPAWN3) begin
            state <= S_IDLE;
            if (pattern_addr == 8'(SONG_LEN - 1)) addr_done    <= 1'b1;
            else                                  pattern_addr <= pattern_addr + 1'b1;
          end else begin
            state <= sched_state_e'(state + 3'd1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arrow_scheduler.sv
// Bench for arrow_scheduler: directed song scenario plus a randomized song, checked every cycle.
module tb_arrow_scheduler;

  localparam int NS     = 8;
  localparam int FPS    = 4;
  localparam int SPD    = 8;
  localparam int SL     = 64;
  localparam int WIN_LO = 400;
  localparam int WIN_HI = 440;
  localparam int RET_Y  = 480;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [9:0]      hc;
  logic [9:0]      vc;
  logic [3:0]      btn;
  logic [3:0]      pattern_data;
  logic [7:0]      pattern_addr;
  logic [NS-1:0]   slot_active;
  logic [2*NS-1:0] slot_lane;
  logic [10*NS-1:0] slot_y;
  logic [3:0]      hit_lanes;
  logic [3:0]      miss_count;
  logic            overflow;
  logic            song_done;

  always #5 clk = ~clk;

  arrow_scheduler #(
    .NUM_SLOTS       (NS),
    .FRAMES_PER_STEP (FPS),
    .SPEED           (SPD),
    .SONG_LEN        (SL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hc           (hc),
    .vc           (vc),
    .enable       (enable),
    .btn          (btn),
    .pattern_addr (pattern_addr),
    .pattern_data (pattern_data),
    .slot_active  (slot_active),
    .slot_lane    (slot_lane),
    .slot_y       (slot_y),
    .hit_lanes    (hit_lanes),
    .miss_count   (miss_count),
    .overflow     (overflow),
    .song_done    (song_done)
  );

  logic [3:0] rom [SL];

  // Reference model: the pool as plain arrays, plus the frame phase (cycles since tick).
  bit         m_act  [NS];
  int         m_y    [NS];
  int         m_lane [NS];
  int         m_phase, m_fc, m_addr, m_miss;
  bit         m_step, m_done, m_sd, m_ovf;
  logic [3:0] m_pend, m_hit;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] hit_acc;
  int         miss_acc, ovf_acc;

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit         tick, any_act, pre_done;
    int         op, k, f;
    logic [3:0] press, pat;
    tick     = (hc == 0) && (vc == 0);
    any_act  = 1'b0;
    foreach (m_act[i]) any_act |= m_act[i];
    pre_done = m_done;
    op       = m_phase;
    m_hit    = '0;
    m_miss   = 0;
    m_ovf    = 1'b0;
    if (reset) begin
      foreach (m_act[i]) begin
        m_act[i] = 1'b0; m_y[i] = 0; m_lane[i] = 0;
      end
      m_phase = 0; m_fc = 0; m_addr = 0;
      m_step = 1'b0; m_done = 1'b0; m_sd = 1'b0; m_pend = '0;
      return;
    end
    press = m_pend | btn;
    case (op)
      0: if (tick && enable) m_phase = 1;
      1: begin
        for (int i = 0; i < NS; i++) begin
          if (m_act[i]) begin
            if (m_y[i] + SPD >= RET_Y) begin
              m_act[i] = 1'b0;
              m_miss++;
            end else begin
              m_y[i] += SPD;
            end
          end
        end
        m_fc = (m_fc + 1) % FPS;
        if (m_fc == 0) m_step = 1'b1;
        m_phase = 2;
      end
      2: begin
        for (int l = 0; l < 4; l++) begin
          if (press[l]) begin
            for (int i = 0; i < NS; i++) begin
              if (m_act[i] && m_lane[i] == l && m_y[i] >= WIN_LO && m_y[i] <= WIN_HI) begin
                m_act[i] = 1'b0;
                m_hit[l] = 1'b1;
                break;
              end
            end
          end
        end
        m_phase = (m_step && !m_done) ? 3 : 0;
        m_step  = 1'b0;
      end
      default: begin
        k   = op - 3;
        pat = rom[m_addr];
        if (pat[k]) begin
          f = -1;
          for (int i = 0; i < NS; i++) if (!m_act[i] && f < 0) f = i;
          if (f >= 0) begin
            m_act[f] = 1'b1; m_y[f] = 0; m_lane[f] = k;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (k == 3) begin
          if (m_addr == SL - 1) m_done = 1'b1;
          else                  m_addr++;
          m_phase = 0;
        end else begin
          m_phase = op + 1;
        end
      end
    endcase
    if (op == 2 || (op == 0 && !enable)) m_pend = '0;
    else                                 m_pend = m_pend | btn;
    if (pre_done && !any_act) m_sd = 1'b1;
  endtask

  task automatic check_all();
    logic [NS-1:0] ea;
    foreach (m_act[i]) ea[i] = m_act[i];
    cmp("slot_active", slot_active, ea);
    cmp("pattern_addr", pattern_addr, m_addr);
    cmp("hit_lanes", hit_lanes, m_hit);
    cmp("miss_count", miss_count, m_miss);
    cmp("overflow", overflow, m_ovf);
    cmp("song_done", song_done, m_sd);
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        cmp($sformatf("slot_lane[%0d]", i), slot_lane[i*2 +: 2], m_lane[i]);
        cmp($sformatf("slot_y[%0d]", i), slot_y[i*10 +: 10], m_y[i]);
      end
    end
    hit_acc  |= hit_lanes;
    miss_acc += miss_count;
    ovf_acc  += overflow;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    pattern_data = rom[pattern_addr];
    btn = '0;
    hc  = 10'd5;
    vc  = 10'd3;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      hc = '0;
      vc = '0;
      step();
      repeat (7) step();
    end
  endtask

  initial begin
    int frames, extra, gap;
    reset = 1'b1; enable = 1'b0; btn = '0; hc = 10'd5; vc = 10'd3;
    hit_acc = '0; miss_acc = 0; ovf_acc = 0;
    for (int i = 0; i < SL; i++) rom[i] = '0;
    rom[0]  = 4'b0001;
    rom[13] = 4'b0010;
    rom[28] = 4'hF; rom[29] = 4'hF; rom[30] = 4'hF;
    rom[45] = 4'b0100; rom[46] = 4'b0100;
    rom[60] = 4'hF;
    pattern_data = rom[0];

    step(); step();
    cmp("reset_active", slot_active, 0);
    cmp("reset_y_zero", int'(slot_y == '0), 1);
    cmp("reset_lane_zero", int'(slot_lane == '0), 1);
    cmp("reset_addr", pattern_addr, 0);

    reset = 1'b0; enable = 1'b1; step();
    ticks(3);
    cmp("no_spawn_before_step", slot_active, 0);
    ticks(1);
    cmp("first_spawn_active", slot_active, 8'h01);
    cmp("first_spawn_lane", slot_lane[1:0], 0);
    cmp("first_spawn_y", slot_y[9:0], 0);
    cmp("first_spawn_addr", pattern_addr, 1);

    ticks(50);
    cmp("fall_y_400", slot_y[9:0], 400);
    btn = 4'b0001; step();
    hit_acc = '0;
    ticks(1);
    cmp("hit_lane0", hit_acc, 4'b0001);
    cmp("hit_slot0_cleared", slot_active, 0);

    ticks(1);
    cmp("arrow_b_spawn", slot_active, 8'h01);
    cmp("arrow_b_lane", slot_lane[1:0], 1);
    ticks(59);
    cmp("arrow_b_y472", slot_y[9:0], 472);
    miss_acc = 0;
    ticks(1);
    cmp("miss_count_one", miss_acc, 1);
    cmp("refill_after_miss", slot_active, 8'h0F);

    ticks(4);
    cmp("pool_full", slot_active, 8'hFF);
    ovf_acc = 0;
    ticks(4);
    cmp("overflow_pulses", ovf_acc, 4);
    cmp("pool_still_full", slot_active, 8'hFF);

    ticks(60);
    cmp("lane2_first", slot_active, 8'h01);
    ticks(53);
    cmp("lane2_both", slot_active, 8'h03);
    cmp("lane2_c_y", slot_y[9:0], 424);
    cmp("lane2_d_y", slot_y[19:10], 392);
    btn = 4'b0100; step();
    hit_acc = '0;
    ticks(1);
    cmp("lane2_hit1", hit_acc, 4'b0100);
    cmp("lane2_lower_cleared", slot_active, 8'h02);
    btn = 4'b0100; step();
    hit_acc = '0;
    ticks(1);
    cmp("lane2_hit2", hit_acc, 4'b0100);
    cmp("lane2_all_cleared", slot_active, 8'h00);

    ticks(4);
    hc = '0; vc = '0;
    repeat (5) step();
    cmp("pre_reset_active", slot_active, 8'h03);
    reset = 1'b1; step(); reset = 1'b0;
    cmp("midspawn_reset_active", slot_active, 0);
    cmp("midspawn_reset_y", int'(slot_y == '0), 1);
    cmp("midspawn_reset_lane", int'(slot_lane == '0), 1);
    cmp("midspawn_reset_addr", pattern_addr, 0);
    cmp("midspawn_reset_ovf", overflow, 0);

    for (int i = 0; i < SL; i++)
      rom[i] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    frames = 0;
    extra  = 0;
    while (frames < 700 && extra < 3) begin
      if (m_sd) extra++;
      enable = ($urandom_range(0, 19) != 0);
      gap    = $urandom_range(8, 12);
      for (int c = 0; c < gap; c++) begin
        if (c == 0) begin
          hc = '0; vc = '0;
        end else begin
          hc = 10'($urandom_range(0, 799));
          vc = 10'($urandom_range(1, 524));
        end
        for (int l = 0; l < 4; l++) btn[l] = ($urandom_range(0, 31) == 0);
        step();
      end
      frames++;
    end
    cmp("song_done_final", song_done, 1);
    cmp("final_addr", pattern_addr, SL - 1);
    cmp("final_pool_empty", slot_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arrow_scheduler.md
# arrow_scheduler

Sequences falling arrows for the dance game: owns a pool of arrow slots, spawns arrows from an external step-pattern ROM on each beat, and advances every active arrow once per video frame. It also judges button presses against the hit window and retires arrows that fall off screen. It sits between the VGA timing counters, the pattern ROM and the arrow renderer/score logic, and replaces per-arrow free-running movers with one scheduled datapath.

## Interface
Parameters:
- NUM_SLOTS, 8, arrow slots in pool (max simultaneous arrows)
- FRAMES_PER_STEP, 8, frames between pattern steps (beats)
- SPEED, 8, pixels added to slot y per frame
- SPAWN_Y, 0, y of a newly spawned arrow
- HIT_LO / HIT_HI, 400 / 440, inclusive hit window on y
- RETIRE_Y, 480, y at or beyond which an arrow is retired as a miss
- SONG_LEN, 256, number of pattern steps

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- hc, vc  in  10 each  VGA counters; frame tick = (hc==0 && vc==0)
- enable  in  1  run song; 0 freezes the schedule
- btn  in  4  one-cycle press pulses, lanes 0..3
- pattern_addr  out  8  step index to ROM
- pattern_data  in  4  lane mask for current step (1-cycle ROM)
- slot_active  out  NUM_SLOTS  slot valid
- slot_lane  out  2*NUM_SLOTS  lane per slot
- slot_y  out  10*NUM_SLOTS  y per slot
- hit_lanes  out  4  one-cycle pulse per lane hit
- miss_count  out  4  arrows retired this frame, valid one cycle
- overflow  out  1  one-cycle pulse: spawn dropped, no free slot
- song_done  out  1  sticky: pattern exhausted and pool empty

## Operation
- FSM states: IDLE, MOVE, JUDGE, SPAWN0..SPAWN3.
- IDLE: on frame tick with enable=1 → MOVE; otherwise stay. enable=0 also clears pending button latches.
- btn pulses OR into btn_pend[3:0] in any state; cleared at end of JUDGE.
- MOVE, all slots in parallel: y_next = y + SPEED computed 11-bit. If y_next ≥ RETIRE_Y, clear active and count it in miss_count; else write y_next. No wrap possible.
- MOVE also updates frame_cnt: it wraps FRAMES_PER_STEP-1 → 0, and the step flag is set on that wrap.
- JUDGE, per lane with btn_pend set: clear the lowest-index active slot in that lane with HIT_LO ≤ y ≤ HIT_HI and pulse hit_lanes[lane]. At most one arrow per lane per frame. A press with no candidate is ignored.
- After JUDGE: → SPAWN0 if the step flag is set and addr_done=0, else → IDLE.
- SPAWNk: if pattern_data[k], allocate the lowest-index free slot with y=SPAWN_Y and lane=k. If no slot is free, pulse overflow and drop the arrow.
- SPAWN3 → IDLE. In SPAWN3, pattern_addr increments; at SONG_LEN-1 it holds and addr_done is set instead.
- song_done is set when addr_done=1 and slot_active==0. It stays set until reset.
- Reset (any state, mid-spawn included): state IDLE, all slots inactive, slot_y/slot_lane 0, pattern_addr 0, frame_cnt 0, btn_pend 0, addr_done 0, all pulses and song_done 0.

## Timing
- Tick sampled at edge E0 → MOVE. Edge E1: slot_y/active updated; miss_count valid for the cycle after E1.
- E2: JUDGE result registered; hit_lanes valid for one cycle.
- E3..E6: SPAWN0..3. The arrow is visible the cycle after its spawn edge.
- Worst case 7 cycles per frame, far below one line; no tick can be missed.
- pattern_addr is stable from the previous step, so pattern_data is valid in SPAWN0..3.
- A slot freed in MOVE/JUDGE is reusable in the same frame's SPAWN.
- A btn pulse arriving during JUDGE counts for this frame. A pulse arriving after JUDGE counts next frame.
- The first spawn occurs on the FRAMES_PER_STEP-th tick after enable rises.

## Structure
- Shared package ddr_pkg: NUM_LANES=4, lane encoding (0 left, 1 down, 2 up, 3 right), screen geometry (SPAWN_Y, HIT_LO/HI, RETIRE_Y), Y_W=10.
- One sub-module slot_alloc: combinational lowest-free-index priority encoder over ~slot_active, outputs index plus found flag. It is reused for the JUDGE candidate search with a lane/window mask.

## Test plan
- Reset then enable with pattern_data=4'b0001 at addr 0 → after the 8th tick, slot0 active, lane 0, y=0; pattern_addr=1.
- Single arrow falling with SPEED=8 → y=400 after 50 further ticks; btn[0] pulse → hit_lanes=4'b0001, slot0 inactive.
- No press → retired at the frame y_next=480: miss_count=1, slot freed.
- pattern_data=4'hF for 3 consecutive steps with NUM_SLOTS=8 → 8 slots filled, then overflow pulses for the 4 dropped arrows.
- Two arrows in lane 2 both in window, one press → only the lower-index slot cleared; the second press next frame clears the other.
- Reset asserted during SPAWN2 → next cycle all outputs 0, state IDLE; the song restarts from addr 0. With SONG_LEN=2 and the pool drained, song_done=1.
